me_ref_fetch_scheduler: RTL and testbench

//  Sequences external-memory reads that feed the ME buffers. One read port is shared by the

---
 rtl/me_pkg.sv | 16 +
 rtl/me_tile_addr_gen.sv | 56 +++++
 rtl/me_ref_fetch_scheduler.sv | 156 +++++++++++++++
 tb/tb_me_ref_fetch_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared frame geometry defaults and FSM states
// for the ME reference fetch scheduler.
package me_pkg;
  localparam int LINE_WORDS = 480;
  localparam int STRIPS     = 270;
  localparam int REF_BURST  = 24;
  localparam int CUR_BURST  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CMD,
    S_DATA,
    S_DONE
  } fsm_t;
endpackage

// File: rtl/me_tile_addr_gen.sv
// Tile-major burst address generator: col/strip
// counters, latched base, address mult-add, finished.
module me_tile_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 480,
  parameter int STRIPS     = 270,
  parameter int BURST      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              finished
);
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int SW = (STRIPS > 1) ? $clog2(STRIPS) : 1;

  logic [CW-1:0]     col;
  logic [SW-1:0]     strip;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] tile;
  logic              last_col;
  logic              last_strip;

  assign last_col   = (col == CW'(LINE_WORDS - 1));
  assign last_strip = (strip == SW'(STRIPS - 1));

  // Tile index is the linear burst number within the frame.
  assign tile = ADDR_W'(strip) * ADDR_W'(LINE_WORDS)
              + ADDR_W'(col);
  assign addr = base_q + tile * ADDR_W'(BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      strip    <= '0;
      base_q   <= '0;
      finished <= 1'b0;
    end else if (start) begin
      col      <= '0;
      strip    <= '0;
      base_q   <= base;
      finished <= 1'b0;
    end else if (adv && !finished) begin
      if (last_col) begin
        col <= '0;
        if (last_strip) finished <= 1'b1;
        else strip <= strip + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/me_ref_fetch_scheduler.sv
// Shares one memory read port between the reference and
// current-block buffers; arbitrates, issues bursts, routes data.
module me_ref_fetch_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = me_pkg::LINE_WORDS,
  parameter int STRIPS     = me_pkg::STRIPS,
  parameter int REF_BURST  = me_pkg::REF_BURST,
  parameter int CUR_BURST  = me_pkg::CUR_BURST,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] ref_base,
  input  logic [ADDR_W-1:0] cur_base,
  input  logic              ref_req,
  input  logic              cur_req,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [7:0]        mem_cmd_len,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              ref_valid,
  output logic              cur_valid,
  output logic [DATA_W-1:0] buf_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overrun
);
  import me_pkg::*;

  localparam int SV_W = $clog2(STARVE_MAX + 1);

  fsm_t              state, state_nx;
  logic              owner, owner_nx;
  logic [SV_W-1:0]   starve, starve_nx;
  logic [7:0]        beats, beats_nx;
  logic [7:0]        burst_len;
  logic              start;
  logic              ref_adv, cur_adv;
  logic              ref_fin, cur_fin;
  logic              ref_ok, cur_ok;
  logic              cur_forced;
  logic              rd_take;
  logic [ADDR_W-1:0] ref_addr, cur_addr;

  me_tile_addr_gen #(
    .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS),
    .STRIPS(STRIPS), .BURST(REF_BURST)
  ) u_ref_gen (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adv(ref_adv), .base(ref_base),
    .addr(ref_addr), .finished(ref_fin)
  );

  me_tile_addr_gen #(
    .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS),
    .STRIPS(STRIPS), .BURST(CUR_BURST)
  ) u_cur_gen (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adv(cur_adv), .base(cur_base),
    .addr(cur_addr), .finished(cur_fin)
  );

  // owner: 0 = reference buffer, 1 = current buffer
  assign ref_ok     = ref_req & ~ref_fin;
  assign cur_ok     = cur_req & ~cur_fin;
  assign cur_forced = cur_ok && (starve == SV_W'(STARVE_MAX));
  assign burst_len  = owner ? 8'(CUR_BURST) : 8'(REF_BURST);
  assign rd_take    = mem_rd_valid && (state == S_DATA);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    starve_nx     = starve;
    beats_nx      = beats;
    start         = 1'b0;
    ref_adv       = 1'b0;
    cur_adv       = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_len   = '0;
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          start    = 1'b1;
          state_nx = S_ARB;
        end
      end
      S_ARB: begin
        if (ref_ok && !cur_forced) begin
          owner_nx = 1'b0;
          state_nx = S_CMD;
          if (cur_ok) starve_nx = starve + 1'b1;
        end else if (cur_ok) begin
          owner_nx  = 1'b1;
          starve_nx = '0;
          state_nx  = S_CMD;
        end
      end
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = owner ? cur_addr : ref_addr;
        mem_cmd_len   = burst_len;
        if (mem_cmd_ready) begin
          ref_adv  = ~owner;
          cur_adv  = owner;
          beats_nx = '0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_rd_valid) begin
          beats_nx = beats + 8'd1;
          if (beats == burst_len - 8'd1)
            state_nx = (ref_fin && cur_fin) ? S_DONE : S_ARB;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      starve <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      starve <= starve_nx;
      beats  <= beats_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data    <= '0;
      ref_valid   <= 1'b0;
      cur_valid   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (rd_take) buf_data <= mem_rd_data;
      ref_valid   <= rd_take & ~owner;
      cur_valid   <= rd_take & owner;
      err_overrun <= (frame_start && busy)
                  || (mem_rd_valid && state != S_DATA);
    end
  end
endmodule

// File: tb/tb_me_ref_fetch_scheduler.sv
// Randomized bench for me_ref_fetch_scheduler against a
// linear-index arbitration/address model.
module tb_me_ref_fetch_scheduler;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int LW   = 3;
  localparam int NS   = 2;
  localparam int RB   = 24;
  localparam int CB   = 8;
  localparam int SMAX = 4;
  localparam int NT   = LW * NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] ref_base = '0;
  logic [AW-1:0] cur_base = '0;
  logic          ref_req = 1'b0;
  logic          cur_req = 1'b0;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready = 1'b0;
  logic [AW-1:0] mem_cmd_addr;
  logic [7:0]    mem_cmd_len;
  logic          mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          ref_valid;
  logic          cur_valid;
  logic [DW-1:0] buf_data;
  logic          busy;
  logic          frame_done;
  logic          err_overrun;

  always #5 clk = ~clk;

  me_ref_fetch_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .STRIPS(NS),
    .REF_BURST(RB), .CUR_BURST(CB), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .ref_base(ref_base), .cur_base(cur_base),
    .ref_req(ref_req), .cur_req(cur_req),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .ref_valid(ref_valid), .cur_valid(cur_valid),
    .buf_data(buf_data), .busy(busy),
    .frame_done(frame_done), .err_overrun(err_overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int beats_left, ready_hold, ready_pct, rd_pct;
  int done_cnt, err_cnt, both_cnt;
  logic [AW-1:0] cmd_addr_q[$];
  int            cmd_len_q[$];
  logic [DW-1:0] sent_q[$];
  int            sent_burst_q[$];
  logic [DW-1:0] rx_q[$];
  bit            rx_own_q[$];
  bit            exp_own[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];

  task automatic clear_bench();
    beats_left = 0; ready_hold = 0;
    ready_pct = 100; rd_pct = 100;
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    cmd_addr_q.delete(); cmd_len_q.delete();
    sent_q.delete(); sent_burst_q.delete();
    rx_q.delete(); rx_own_q.delete();
  endtask

  // One cycle: observe outputs mid-cycle, then drive the memory side.
  task automatic step();
    logic [DW-1:0] w;
    @(negedge clk);
    if (ref_valid) begin rx_q.push_back(buf_data); rx_own_q.push_back(1'b0); end
    if (cur_valid) begin rx_q.push_back(buf_data); rx_own_q.push_back(1'b1); end
    if (ref_valid && cur_valid) both_cnt++;
    if (frame_done) done_cnt++;
    if (err_overrun) err_cnt++;
    mem_rd_valid = 1'b0;
    if (beats_left > 0 && int'($urandom_range(0, 99)) < rd_pct) begin
      w = {$urandom, $urandom};
      mem_rd_data = w;
      mem_rd_valid = 1'b1;
      sent_q.push_back(w);
      sent_burst_q.push_back(cmd_addr_q.size() - 1);
      beats_left--;
    end
    mem_cmd_ready = 1'b0;
    if (mem_cmd_valid) begin
      if (ready_hold > 0) ready_hold--;
      else if (int'($urandom_range(0, 99)) < ready_pct) begin
        mem_cmd_ready = 1'b1;
        cmd_addr_q.push_back(mem_cmd_addr);
        cmd_len_q.push_back(int'(mem_cmd_len));
        beats_left = int'(mem_cmd_len);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0; ref_req = 1'b0; cur_req = 1'b0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    ref_base = '0; cur_base = '0;
    clear_bench();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [AW-1:0] rb, input logic [AW-1:0] cb);
    ref_base = rb; cur_base = cb;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input bit poke, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < 4000 && !ok) begin
      step(); n++;
      if (frame_done) begin
        ok = 1'b1;
        if (poke) begin frame_start = 1'b1; step(); frame_start = 1'b0; end
      end
    end
    repeat (3) step();
  endtask

  // Grants from the arbitration rules, bursts numbered linearly per frame.
  task automatic build_model(input logic [AW-1:0] rb, input logic [AW-1:0] cb);
    int kr, kc, st;
    exp_own.delete(); exp_addr.delete(); exp_len.delete();
    kr = 0; kc = 0; st = 0;
    while (kr < NT || kc < NT) begin
      if (kr < NT && !(kc < NT && st == SMAX)) begin
        exp_own.push_back(1'b0);
        exp_addr.push_back(rb + AW'(kr * RB));
        exp_len.push_back(RB);
        kr++;
        if (kc < NT && st < SMAX) st++;
      end else begin
        exp_own.push_back(1'b1);
        exp_addr.push_back(cb + AW'(kc * CB));
        exp_len.push_back(CB);
        kc++;
        st = 0;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid got %b want 0", mem_cmd_valid); end
    n_cmp++; if (mem_cmd_addr !== '0) begin n_bad++; $display("FAIL reset_cmd_addr got %h want 0", mem_cmd_addr); end
    n_cmp++; if (mem_cmd_len !== 8'd0) begin n_bad++; $display("FAIL reset_cmd_len got %0d want 0", mem_cmd_len); end
    n_cmp++; if ({ref_valid, cur_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids got %b want 00", {ref_valid, cur_valid}); end
    n_cmp++; if (buf_data !== '0) begin n_bad++; $display("FAIL reset_buf_data got %h want 0", buf_data); end
    n_cmp++; if ({busy, frame_done, err_overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b want 000", {busy, frame_done, err_overrun}); end
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_ref_only();
    int n;
    do_reset();
    ready_pct = 50; rd_pct = 80;
    ref_req = 1'b1;
    start_frame(32'h1000, $urandom);
    n = 0;
    while (cmd_addr_q.size() < 3 && n < 500) begin step(); n++; end
    n_cmp++; if (cmd_addr_q.size() < 3) begin n_bad++; $display("FAIL ref_only_count got %0d want 3", cmd_addr_q.size()); end
    for (int i = 0; i < 3 && i < cmd_addr_q.size(); i++) begin
      n_cmp++;
      if (cmd_addr_q[i] !== 32'h1000 + AW'(i * RB) || cmd_len_q[i] !== RB) begin
        n_bad++;
        $display("FAIL ref_only_cmd%0d got addr=%h len=%0d want addr=%h len=%0d",
                 i, cmd_addr_q[i], cmd_len_q[i], 32'h1000 + AW'(i * RB), RB);
      end
    end
    for (int j = 0; j < rx_own_q.size(); j++) begin
      n_cmp++; if (rx_own_q[j] !== 1'b0) begin n_bad++; $display("FAIL ref_only_route word%0d got cur want ref", j); end
    end
  endtask

  task automatic test_cmd_stall();
    logic [AW-1:0] rb, a0;
    logic [7:0] l0;
    int n;
    do_reset();
    rb = $urandom;
    ready_hold = 5;
    ref_req = 1'b1;
    start_frame(rb, $urandom);
    n = 0;
    while (!mem_cmd_valid && n < 50) begin step(); n++; end
    a0 = mem_cmd_addr; l0 = mem_cmd_len;
    n_cmp++; if (a0 !== rb || l0 !== 8'(RB)) begin n_bad++; $display("FAIL stall_first got addr=%h len=%0d want addr=%h len=%0d", a0, l0, rb, RB); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== a0 || mem_cmd_len !== l0 || cmd_addr_q.size() != 0) begin
        n_bad++;
        $display("FAIL stall_hold%0d got v=%b addr=%h len=%0d acc=%0d want v=1 addr=%h len=%0d acc=0",
                 i, mem_cmd_valid, mem_cmd_addr, mem_cmd_len, cmd_addr_q.size(), a0, l0);
      end
    end
    n = 0;
    while (cmd_addr_q.size() < 2 && n < 200) begin step(); n++; end
    n_cmp++;
    if (cmd_addr_q.size() < 2) begin n_bad++; $display("FAIL stall_accept got %0d cmds want 2", cmd_addr_q.size()); end
    else if (cmd_addr_q[0] !== rb || cmd_addr_q[1] !== rb + AW'(RB)) begin
      n_bad++;
      $display("FAIL stall_advance got %h,%h want %h,%h", cmd_addr_q[0], cmd_addr_q[1], rb, rb + AW'(RB));
    end
  endtask

  task automatic test_full_frames();
    logic [AW-1:0] rb, cb;
    logic eo;
    bit ok;
    int exp_err;
    bit pat [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int it = 0; it < 3; it++) begin
      do_reset();
      rb = (it == 2) ? 32'hFFFF_FFF0 : $urandom;
      cb = (it == 2) ? 32'hFFFF_FFF8 : $urandom;
      ready_pct = (it == 0) ? 60 : int'($urandom_range(30, 100));
      rd_pct = (it == 0) ? 70 : int'($urandom_range(30, 100));
      exp_err = (it == 0) ? 1 : 0;
      build_model(rb, cb);
      ref_req = 1'b1; cur_req = 1'b1;
      start_frame(rb, cb);
      run_frame(it == 0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame%0d_timeout got no frame_done want pulse", it); end
      n_cmp++; if (cmd_addr_q.size() != exp_addr.size()) begin n_bad++; $display("FAIL frame%0d_cmds got %0d want %0d", it, cmd_addr_q.size(), exp_addr.size()); end
      for (int i = 0; i < cmd_addr_q.size() && i < exp_addr.size(); i++) begin
        n_cmp++;
        if (cmd_addr_q[i] !== exp_addr[i] || cmd_len_q[i] !== exp_len[i]) begin
          n_bad++;
          $display("FAIL frame%0d_cmd%0d got addr=%h len=%0d want addr=%h len=%0d",
                   it, i, cmd_addr_q[i], cmd_len_q[i], exp_addr[i], exp_len[i]);
        end
      end
      n_cmp++; if (rx_q.size() != sent_q.size()) begin n_bad++; $display("FAIL frame%0d_words got %0d want %0d", it, rx_q.size(), sent_q.size()); end
      for (int j = 0; j < rx_q.size() && j < sent_q.size(); j++) begin
        eo = (sent_burst_q[j] < exp_own.size()) ? exp_own[sent_burst_q[j]] : 1'bx;
        n_cmp++;
        if (rx_q[j] !== sent_q[j] || rx_own_q[j] !== eo) begin
          n_bad++;
          $display("FAIL frame%0d_word%0d got data=%h own=%b want data=%h own=%b",
                   it, j, rx_q[j], rx_own_q[j], sent_q[j], eo);
        end
      end
      if (it == 0) begin
        for (int i = 0; i < 6; i++) begin
          for (int j = 0; j < sent_burst_q.size() && j < rx_own_q.size(); j++) begin
            if (sent_burst_q[j] == i) begin
              n_cmp++;
              if (rx_own_q[j] !== pat[i]) begin n_bad++; $display("FAIL grant_order%0d got own=%b want own=%b", i, rx_own_q[j], pat[i]); end
              break;
            end
          end
        end
      end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL frame%0d_done got %0d pulses want 1", it, done_cnt); end
      n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL frame%0d_both_valid got %0d want 0", it, both_cnt); end
      n_cmp++; if (err_cnt != exp_err) begin n_bad++; $display("FAIL frame%0d_err got %0d want %0d", it, err_cnt, exp_err); end
      n_cmp++; if (busy !== 1'b0 || mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL frame%0d_idle got busy=%b v=%b want 0 0", it, busy, mem_cmd_valid); end
    end
  endtask

  task automatic test_errors();
    logic [AW-1:0] rb, cb;
    bit ok;
    do_reset();
    rb = $urandom; cb = $urandom;
    start_frame(rb, cb);
    repeat (3) step();
    n_cmp++; if (busy !== 1'b1 || mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL err_arb_wait got busy=%b v=%b want 1 0", busy, mem_cmd_valid); end
    mem_rd_valid = 1'b1; mem_rd_data = {$urandom, $urandom};
    step();
    step();
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL err_stray got %0d pulses want 1", err_cnt); end
    n_cmp++; if (rx_q.size() != 0 || buf_data !== '0) begin n_bad++; $display("FAIL err_stray_drop got words=%0d buf=%h want 0 0", rx_q.size(), buf_data); end
    n_cmp++; if (busy !== 1'b1 || mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL err_stray_state got busy=%b v=%b want 1 0", busy, mem_cmd_valid); end
    ref_base = rb ^ 32'h000F_FFF0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    n_cmp++; if (err_cnt != 2) begin n_bad++; $display("FAIL err_restart got %0d pulses want 2", err_cnt); end
    build_model(rb, cb);
    ready_pct = 70; rd_pct = 70;
    ref_req = 1'b1; cur_req = 1'b1;
    run_frame(1'b0, ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL err_frame_done got ok=%b pulses=%0d want 1 1", ok, done_cnt); end
    n_cmp++; if (cmd_addr_q.size() != exp_addr.size()) begin n_bad++; $display("FAIL err_frame_cmds got %0d want %0d", cmd_addr_q.size(), exp_addr.size()); end
    for (int i = 0; i < cmd_addr_q.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if (cmd_addr_q[i] !== exp_addr[i]) begin n_bad++; $display("FAIL err_frame_cmd%0d got %h want %h", i, cmd_addr_q[i], exp_addr[i]); end
    end
    n_cmp++; if (err_cnt != 2) begin n_bad++; $display("FAIL err_final got %0d pulses want 2", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] rb;
    int n;
    do_reset();
    ref_req = 1'b1; cur_req = 1'b1;
    start_frame($urandom, $urandom);
    n = 0;
    while (rx_q.size() < 3 && n < 200) begin step(); n++; end
    n_cmp++; if (rx_q.size() < 3) begin n_bad++; $display("FAIL mid_reach_data got %0d words want 3", rx_q.size()); end
    #2;
    rst_n = 1'b0; mem_rd_valid = 1'b0; mem_cmd_ready = 1'b0;
    #1;
    n_cmp++; if ({mem_cmd_valid, ref_valid, cur_valid} !== 3'b000) begin n_bad++; $display("FAIL mid_valids got %b want 000", {mem_cmd_valid, ref_valid, cur_valid}); end
    n_cmp++; if (buf_data !== '0 || mem_cmd_addr !== '0 || mem_cmd_len !== 8'd0) begin n_bad++; $display("FAIL mid_data got buf=%h addr=%h len=%0d want 0", buf_data, mem_cmd_addr, mem_cmd_len); end
    n_cmp++; if ({busy, frame_done, err_overrun} !== 3'b000) begin n_bad++; $display("FAIL mid_status got %b want 000", {busy, frame_done, err_overrun}); end
    clear_bench();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rb = $urandom;
    start_frame(rb, $urandom);
    n = 0;
    while (cmd_addr_q.size() < 1 && n < 50) begin step(); n++; end
    n_cmp++;
    if (cmd_addr_q.size() < 1) begin n_bad++; $display("FAIL mid_restart got no cmd want one"); end
    else if (cmd_addr_q[0] !== rb || cmd_len_q[0] !== RB) begin
      n_bad++;
      $display("FAIL mid_restart got addr=%h len=%0d want addr=%h len=%0d", cmd_addr_q[0], cmd_len_q[0], rb, RB);
    end
  endtask

  initial begin
    clear_bench();
    test_reset();
    test_ref_only();
    test_cmd_stall();
    test_full_frames();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
